// File: rtl/lsb_mem_ctrl_pkg.sv
// Shared types for the LSB-side memory controller: op codes, bus constants,
// controller state codes and byte helpers.
package lsb_mem_ctrl_pkg;

    typedef enum logic [3:0] {
        OPTYPE_LB, OPTYPE_LBU, OPTYPE_LH, OPTYPE_LHU, OPTYPE_LW,
        OPTYPE_SB, OPTYPE_SH, OPTYPE_SW
    } opcode_t;

    localparam logic        LOAD_MEM  = 1'b0;
    localparam logic        STORE_MEM = 1'b1;
    localparam logic        TRUE      = 1'b1;
    localparam logic        FALSE     = 1'b0;
    localparam logic [31:0] ZERO      = 32'h0;

    typedef enum logic [2:0] {
        MC_IDLE, MC_RD, MC_WR, MC_WSTALL, MC_DONE
    } mc_state_t;

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    // Only byte, half and word transfers touch the RAM.
    function automatic logic tot_ok(input logic [2:0] t);
        return (t == 3'd1) || (t == 3'd2) || (t == 3'd4);
    endfunction

endpackage

// File: rtl/lsb_mem_ctrl_if.sv
// Request/response bus between the load-store buffer (master) and the
// memory controller (slave).
interface lsb_mem_ctrl_if #(parameter int ADDR_W = 32);
    import lsb_mem_ctrl_pkg::*;

    logic              ena_i;
    logic              wr_i;
    opcode_t           optype_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       data_i;
    logic [2:0]        totbyte_i;
    logic              rdy_o;
    logic [31:0]       data_o;

    modport master (output ena_i, wr_i, optype_i, addr_i, data_i, totbyte_i,
                    input  rdy_o, data_o);
    modport slave  (input  ena_i, wr_i, optype_i, addr_i, data_i, totbyte_i,
                    output rdy_o, data_o);
endinterface

// File: rtl/lsb_mem_ctrl_mem_load_ext.sv
// Combinational load-result extension: sign/zero-extends the assembled raw
// word according to the load op type.
module mem_load_ext
    import lsb_mem_ctrl_pkg::*;
(
    input  opcode_t     optype_i,
    input  logic [31:0] raw_i,
    output logic [31:0] ext_o
);
    always_comb begin
        ext_o = raw_i;
        case (optype_i)
            OPTYPE_LB:  ext_o = {{24{raw_i[7]}},  raw_i[7:0]};
            OPTYPE_LBU: ext_o = {24'h0,           raw_i[7:0]};
            OPTYPE_LH:  ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
            OPTYPE_LHU: ext_o = {16'h0,           raw_i[15:0]};
            default:    ext_o = raw_i;
        endcase
    end
endmodule

// File: rtl/lsb_mem_ctrl.sv
// LSB memory controller: serialises one load/store into byte accesses on the
// 8-bit RAM bus. Optional IO write stall is enabled by MEMCTL_IO_STALL_EN.
module lsb_mem_ctrl
    import lsb_mem_ctrl_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h30000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    lsb_mem_ctrl_if.slave     lsb,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    mc_state_t         state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        tot_q, tot_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    opcode_t           op_q, op_d;
    logic [31:0]       buf_q, buf_d;
    logic              rdy_q, rdy_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;

    logic [2:0]        cnt_inc;
    logic [2:0]        cnt_m1;
    logic              more;
    logic [ADDR_W-1:0] nxt_addr;
    logic [31:0]       raw_w;
    logic [31:0]       ext_w;

    assign cnt_inc  = cnt_q + 3'd1;
    assign cnt_m1   = cnt_q - 3'd1;
    assign more     = cnt_inc < tot_q;
    assign nxt_addr = addr_q + ADDR_W'(cnt_inc);

`ifdef MEMCTL_IO_STALL_EN
    logic io_hit_new, io_hit_q;
    assign io_hit_new = lsb.addr_i >= IO_BASE;
    assign io_hit_q   = addr_q >= IO_BASE;
`else
    logic unused_io;
    assign unused_io = io_buffer_full ^ (^IO_BASE);
`endif

    // In RD with cnt=c the RAM returns the byte addressed in the previous
    // cycle, i.e. lane c-1; merge it so the final lane is usable at once.
    always_comb begin
        raw_w = buf_q;
        if (cnt_q != 3'd0)
            raw_w[{cnt_m1[1:0], 3'b000} +: 8] = mem_din;
    end

    mem_load_ext u_ext (
        .optype_i (op_q),
        .raw_i    (raw_w),
        .ext_o    (ext_w)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tot_d      = tot_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        buf_d      = buf_q;
        rdy_d      = rdy_q;
        data_d     = data_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;

        case (state_q)
            MC_IDLE: begin
                rdy_d = FALSE;
                if (rollback) begin
                    mem_a_d = '0;
                end else if (lsb.ena_i) begin
                    addr_d  = lsb.addr_i;
                    wdata_d = lsb.data_i;
                    op_d    = lsb.optype_i;
                    tot_d   = lsb.totbyte_i;
                    cnt_d   = 3'd0;
                    buf_d   = ZERO;
                    if (!tot_ok(lsb.totbyte_i)) begin
                        rdy_d   = TRUE;
                        data_d  = ZERO;
                        state_d = MC_DONE;
                    end else if (lsb.wr_i == LOAD_MEM) begin
                        mem_a_d = lsb.addr_i;
                        state_d = MC_RD;
                    end else begin
                        mem_a_d = lsb.addr_i;
`ifdef MEMCTL_IO_STALL_EN
                        if (io_hit_new && io_buffer_full) begin
                            mem_wr_d = FALSE;
                            state_d  = MC_WSTALL;
                        end else
`endif
                        begin
                            mem_wr_d   = TRUE;
                            mem_dout_d = lsb.data_i[7:0];
                            state_d    = MC_WR;
                        end
                    end
                end
            end

            MC_RD: begin
                if (rollback) begin
                    mem_a_d = '0;
                    state_d = MC_IDLE;
                end else begin
                    buf_d = raw_w;
                    if (more)
                        mem_a_d = nxt_addr;
                    if (cnt_q == tot_q) begin
                        data_d  = ext_w;
                        rdy_d   = TRUE;
                        mem_a_d = '0;
                        state_d = MC_DONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            // Stores are already committed, so rollback does not stop them.
            MC_WR: begin
                if (more) begin
                    cnt_d   = cnt_inc;
                    mem_a_d = nxt_addr;
`ifdef MEMCTL_IO_STALL_EN
                    if (io_hit_q && io_buffer_full) begin
                        mem_wr_d = FALSE;
                        state_d  = MC_WSTALL;
                    end else
`endif
                    begin
                        mem_dout_d = get_byte(wdata_q, cnt_inc[1:0]);
                    end
                end else begin
                    mem_wr_d = FALSE;
                    mem_a_d  = '0;
                    rdy_d    = TRUE;
                    data_d   = ZERO;
                    state_d  = MC_DONE;
                end
            end

`ifdef MEMCTL_IO_STALL_EN
            MC_WSTALL: begin
                if (!io_buffer_full) begin
                    mem_wr_d   = TRUE;
                    mem_dout_d = get_byte(wdata_q, cnt_q[1:0]);
                    state_d    = MC_WR;
                end
            end
`endif

            MC_DONE: begin
                rdy_d   = FALSE;
                state_d = MC_IDLE;
            end

            default: begin
                rdy_d    = FALSE;
                mem_wr_d = FALSE;
                mem_a_d  = '0;
                state_d  = MC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MC_IDLE;
            cnt_q      <= 3'd0;
            tot_q      <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= ZERO;
            op_q       <= OPTYPE_LB;
            buf_q      <= ZERO;
            rdy_q      <= FALSE;
            data_q     <= ZERO;
            mem_a_q    <= '0;
            mem_dout_q <= 8'h0;
            mem_wr_q   <= FALSE;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tot_q      <= tot_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            buf_q      <= buf_d;
            rdy_q      <= rdy_d;
            data_q     <= data_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign lsb.rdy_o  = rdy_q;
    assign lsb.data_o = data_q;
    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign mem_wr     = mem_wr_q;

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// Scoreboard bench for lsb_mem_ctrl: directed requests push expected
// (data, completion cycle); a negedge monitor pops on every rdy_o pulse.
module tb_lsb_mem_ctrl;
    import lsb_mem_ctrl_pkg::*;

    typedef struct { logic [31:0] d; int c; } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic        io_full = 1'b0;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  ram [0:262143];
    logic        pl_we = 1'b0;
    logic [17:0] pl_a = '0;
    logic [7:0]  pl_d = '0;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [39:0] wr_q[$];

    lsb_mem_ctrl_if #(.ADDR_W(32)) lsb ();

    lsb_mem_ctrl #(.ADDR_W(32), .IO_BASE(32'h30000)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .lsb            (lsb),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte RAM, frozen by rdy like the rest of the system.
    always @(posedge clk) begin
        if (pl_we)
            ram[pl_a] <= pl_d;
        else if (rdy) begin
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
            mem_din <= ram[mem_a[17:0]];
        end
    end

    task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr) wr_q.push_back({mem_a, mem_dout});
            if (lsb.rdy_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rdy cycle=%0d data=%h", cyc, lsb.data_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rdy_data", {8'h0, lsb.data_o}, {8'h0, e.d});
                    chk("rdy_cycle", 40'(cyc), 40'(e.c));
                end
            end
        end
    end

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        pl_a = a; pl_d = d; pl_we = 1'b1;
        @(posedge clk); #1 pl_we = 1'b0;
    endtask

    // Called #1 after a posedge; the next posedge is the accept edge.
    task automatic issue(input logic w, input opcode_t op, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] tot,
                         input logic [31:0] ed, input int lat);
        lsb.ena_i = 1'b1; lsb.wr_i = w; lsb.optype_i = op;
        lsb.addr_i = a; lsb.data_i = d; lsb.totbyte_i = tot;
        if (lat >= 0) exp_q.push_back('{ed, cyc + 1 + lat});
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lsb.rdy_o) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL rdy_timeout cycle=%0d got=no_rdy expected=rdy", cyc);
        end
        @(posedge clk); #1 lsb.ena_i = 1'b0;
    endtask

    task automatic req(input logic w, input opcode_t op, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] tot,
                       input logic [31:0] ed, input int lat);
        issue(w, op, a, d, tot, ed, lat);
        wait_done();
    endtask

    initial begin
        lsb.ena_i = 1'b0; lsb.wr_i = 1'b0; lsb.optype_i = OPTYPE_LB;
        lsb.addr_i = '0; lsb.data_i = '0; lsb.totbyte_i = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        poke(18'h100, 8'h78); poke(18'h101, 8'h56);
        poke(18'h102, 8'h34); poke(18'h103, 8'h12);
        poke(18'h010, 8'h80);
        poke(18'h020, 8'h01); poke(18'h021, 8'h80);
        poke(18'h3FFFF, 8'h34); poke(18'h00000, 8'h12);
        poke(18'h500, 8'h11);

        @(negedge clk);
        chk("rst_rdy_o",    {39'h0, lsb.rdy_o}, 40'h0);
        chk("rst_data_o",   {8'h0, lsb.data_o}, 40'h0);
        chk("rst_mem_a",    {8'h0, mem_a},      40'h0);
        chk("rst_mem_dout", {32'h0, mem_dout},  40'h0);
        chk("rst_mem_wr",   {39'h0, mem_wr},    40'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // LW: address walks 100..103, result in cycle 6
        issue(LOAD_MEM, OPTYPE_LW, 32'h100, 32'h0, 3'd4, 32'h12345678, 5);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lw_mem_a", {8'h0, mem_a}, {8'h0, 32'h100 + 32'(i)});
        end
        wait_done();

        req(LOAD_MEM, OPTYPE_LB,  32'h10, 32'h0, 3'd1, 32'hFFFFFF80, 2);
        req(LOAD_MEM, OPTYPE_LBU, 32'h10, 32'h0, 3'd1, 32'h00000080, 2);
        req(LOAD_MEM, OPTYPE_LH,  32'h20, 32'h0, 3'd2, 32'hFFFF8001, 3);
        req(LOAD_MEM, OPTYPE_LHU, 32'h20, 32'h0, 3'd2, 32'h00008001, 3);

        // SW: four write strobes, little-endian byte order
        wr_q.delete();
        req(STORE_MEM, OPTYPE_SW, 32'h200, 32'hDEADBEEF, 3'd4, 32'h0, 4);
        chk("sw_wr_count", 40'(wr_q.size()), 40'd4);
        if (wr_q.size() == 4) begin
            chk("sw_wr0", wr_q[0], {32'h200, 8'hEF});
            chk("sw_wr1", wr_q[1], {32'h201, 8'hBE});
            chk("sw_wr2", wr_q[2], {32'h202, 8'hAD});
            chk("sw_wr3", wr_q[3], {32'h203, 8'hDE});
        end
        req(LOAD_MEM, OPTYPE_LW, 32'h200, 32'h0, 3'd4, 32'hDEADBEEF, 5);

        // back-to-back SB then LB
        req(STORE_MEM, OPTYPE_SB, 32'h300, 32'h000000A5, 3'd1, 32'h0, 1);
        req(LOAD_MEM,  OPTYPE_LB, 32'h300, 32'h0, 3'd1, 32'hFFFFFFA5, 2);

        // unsupported byte count: immediate completion, no RAM traffic
        wr_q.delete();
        req(STORE_MEM, OPTYPE_SW, 32'h600, 32'h12345678, 3'd3, 32'h0, 0);
        chk("inv_no_write", 40'(wr_q.size()), 40'd0);

        // rollback in cycle 3 of LW: no completion
        issue(LOAD_MEM, OPTYPE_LW, 32'h100, 32'h0, 3'd4, 32'h0, -1);
        repeat (3) @(posedge clk);
        #1 rollback = 1'b1; lsb.ena_i = 1'b0;
        @(posedge clk); #1 rollback = 1'b0;
        @(negedge clk);
        chk("rb_lw_mem_a", {8'h0, mem_a}, 40'h0);
        repeat (6) @(posedge clk);
        #1;
        req(LOAD_MEM, OPTYPE_LB, 32'h10, 32'h0, 3'd1, 32'hFFFFFF80, 2);

        // rollback with ena in the same IDLE cycle drops the request
        wr_q.delete();
        issue(STORE_MEM, OPTYPE_SB, 32'h500, 32'h77, 3'd1, 32'h0, -1);
        rollback = 1'b1;
        @(posedge clk); #1 rollback = 1'b0; lsb.ena_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rb_ena_no_write", 40'(wr_q.size()), 40'd0);
        req(LOAD_MEM, OPTYPE_LBU, 32'h500, 32'h0, 3'd1, 32'h00000011, 2);

        // rollback during SH is ignored
        wr_q.delete();
        issue(STORE_MEM, OPTYPE_SH, 32'h400, 32'h0000BEEF, 3'd2, 32'h0, 2);
        @(posedge clk); #1 rollback = 1'b1;
        @(posedge clk); #1 rollback = 1'b0;
        wait_done();
        chk("rb_sh_wr_count", 40'(wr_q.size()), 40'd2);
        req(LOAD_MEM, OPTYPE_LHU, 32'h400, 32'h0, 3'd2, 32'h0000BEEF, 3);

        // rdy low for 3 cycles mid-load stretches latency by 3
        issue(LOAD_MEM, OPTYPE_LH, 32'h20, 32'h0, 3'd2, 32'hFFFF8001, 6);
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
        wait_done();

        // address wraps from 0xFFFFFFFF to 0
        req(LOAD_MEM, OPTYPE_LHU, 32'hFFFFFFFF, 32'h0, 3'd2, 32'h00001234, 3);

        // IO-mapped store with the IO FIFO full
        wr_q.delete();
        io_full = 1'b1;
`ifdef MEMCTL_IO_STALL_EN
        issue(STORE_MEM, OPTYPE_SB, 32'h30000, 32'h5A, 3'd1, 32'h0, 6);
        repeat (5) @(posedge clk);
        #1;
        chk("io_stall_no_write", 40'(wr_q.size()), 40'd0);
        io_full = 1'b0;
        wait_done();
`else
        req(STORE_MEM, OPTYPE_SB, 32'h30000, 32'h5A, 3'd1, 32'h0, 1);
        io_full = 1'b0;
`endif
        chk("io_wr_count", 40'(wr_q.size()), 40'd1);
        req(LOAD_MEM, OPTYPE_LBU, 32'h30000, 32'h0, 3'd1, 32'h0000005A, 2);

        repeat (4) @(posedge clk);
        chk("exp_q_drained", 40'(exp_q.size()), 40'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
